// File: rtl/vga_timing_pkg.sv
// Shared raster timing constants, phase type and total-length helper for the VGA timing block.
package vga_timing_pkg;

    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FRONT  = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BACK   = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FRONT  = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BACK   = 33;

    localparam int unsigned POS_W     = 10;
    localparam int unsigned MAX_TOTAL = 1024;

    typedef enum logic [1:0] {
        PH_ACTIVE,
        PH_FRONT,
        PH_SYNC,
        PH_BACK
    } phase_t;

    function automatic int unsigned axis_total(input int unsigned active,
                                               input int unsigned front,
                                               input int unsigned sync,
                                               input int unsigned back);
        return active + front + sync + back;
    endfunction

    localparam int unsigned DEF_H_TOTAL =
        axis_total(DEF_H_ACTIVE, DEF_H_FRONT, DEF_H_SYNC, DEF_H_BACK);
    localparam int unsigned DEF_V_TOTAL =
        axis_total(DEF_V_ACTIVE, DEF_V_FRONT, DEF_V_SYNC, DEF_V_BACK);

endpackage

// File: rtl/vga_axis_timer.sv
// One raster axis: position counter plus ACTIVE/FRONT/SYNC/BACK phase FSM.
// All outputs describe the next-state position so the parent can register them without skew.
module vga_axis_timer
    import vga_timing_pkg::*;
#(
    parameter int unsigned ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned FRONT  = DEF_H_FRONT,
    parameter int unsigned SYNC   = DEF_H_SYNC,
    parameter int unsigned BACK   = DEF_H_BACK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             step,
    input  logic             sync_pol,
    output logic [POS_W-1:0] pos,
    output phase_t           phase,
    output logic             wrap,
    output logic             sync,
    output logic             active
);

    localparam int unsigned      TOTAL   = axis_total(ACTIVE, FRONT, SYNC, BACK);
    localparam logic [POS_W-1:0] LAST    = POS_W'(TOTAL - 1);
    localparam logic [POS_W-1:0] B_FRONT = POS_W'(ACTIVE);
    localparam logic [POS_W-1:0] B_SYNC  = POS_W'(ACTIVE + FRONT);
    localparam logic [POS_W-1:0] B_BACK  = POS_W'(ACTIVE + FRONT + SYNC);

    logic [POS_W-1:0] r_cnt;
    logic [POS_W-1:0] w_cnt_d;
    phase_t           r_phase;
    phase_t           w_phase_d;

    always_comb begin
        w_cnt_d   = r_cnt;
        w_phase_d = r_phase;
        wrap      = 1'b0;
        if (step) begin
            if (r_cnt == LAST) begin
                w_cnt_d = '0;
                wrap    = 1'b1;
            end else begin
                w_cnt_d = r_cnt + POS_W'(1);
            end
            // Later boundaries first so a zero-length phase is skipped cleanly.
            if (wrap) begin
                w_phase_d = PH_ACTIVE;
            end else if (w_cnt_d == B_BACK) begin
                w_phase_d = PH_BACK;
            end else if (w_cnt_d == B_SYNC) begin
                w_phase_d = PH_SYNC;
            end else if (w_cnt_d == B_FRONT) begin
                w_phase_d = PH_FRONT;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= LAST;
            r_phase <= PH_BACK;
        end else begin
            r_cnt   <= w_cnt_d;
            r_phase <= w_phase_d;
        end
    end

    assign pos    = w_cnt_d;
    assign phase  = w_phase_d;
    assign sync   = (w_phase_d == PH_SYNC) ? sync_pol : ~sync_pol;
    assign active = (w_phase_d == PH_ACTIVE);

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA raster timing generator: registered sync, blanking, coordinates, strobes and frame counter.
module vga_timing_ctrl
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE   = DEF_H_ACTIVE,
    parameter int unsigned H_FRONT    = DEF_H_FRONT,
    parameter int unsigned H_SYNC     = DEF_H_SYNC,
    parameter int unsigned H_BACK     = DEF_H_BACK,
    parameter int unsigned V_ACTIVE   = DEF_V_ACTIVE,
    parameter int unsigned V_FRONT    = DEF_V_FRONT,
    parameter int unsigned V_SYNC     = DEF_V_SYNC,
    parameter int unsigned V_BACK     = DEF_V_BACK,
    parameter logic        H_SYNC_POL = 1'b0,
    parameter logic        V_SYNC_POL = 1'b0,
    parameter int unsigned FRAME_W    = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    output logic [POS_W-1:0]   hpos,
    output logic [POS_W-1:0]   vpos,
    output logic               display_on,
    output logic               hsync,
    output logic               vsync,
    output logic               line_start,
    output logic               frame_start,
    output logic [FRAME_W-1:0] frame_count
);

    localparam int unsigned H_TOTAL = axis_total(H_ACTIVE, H_FRONT, H_SYNC, H_BACK);
    localparam int unsigned V_TOTAL = axis_total(V_ACTIVE, V_FRONT, V_SYNC, V_BACK);

    if (H_TOTAL > MAX_TOTAL) begin : g_h_total_err
        $error("vga_timing_ctrl: H_TOTAL exceeds 1024");
    end
    if (V_TOTAL > MAX_TOTAL) begin : g_v_total_err
        $error("vga_timing_ctrl: V_TOTAL exceeds 1024");
    end

    logic [POS_W-1:0] w_hpos_d;
    logic [POS_W-1:0] w_vpos_d;
    phase_t           w_h_phase;
    phase_t           w_v_phase;
    logic             w_h_wrap;
    logic             w_v_wrap;
    logic             w_hsync_d;
    logic             w_vsync_d;
    logic             w_h_active;
    logic             w_v_active;
    logic             w_frame_wrap;
    logic             w_unused_phase;

    vga_axis_timer #(
        .ACTIVE (H_ACTIVE),
        .FRONT  (H_FRONT),
        .SYNC   (H_SYNC),
        .BACK   (H_BACK)
    ) u_h_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .step     (ena),
        .sync_pol (H_SYNC_POL),
        .pos      (w_hpos_d),
        .phase    (w_h_phase),
        .wrap     (w_h_wrap),
        .sync     (w_hsync_d),
        .active   (w_h_active)
    );

    vga_axis_timer #(
        .ACTIVE (V_ACTIVE),
        .FRONT  (V_FRONT),
        .SYNC   (V_SYNC),
        .BACK   (V_BACK)
    ) u_v_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .step     (ena & w_h_wrap),
        .sync_pol (V_SYNC_POL),
        .pos      (w_vpos_d),
        .phase    (w_v_phase),
        .wrap     (w_v_wrap),
        .sync     (w_vsync_d),
        .active   (w_v_active)
    );

    assign w_unused_phase = ^{w_h_phase, w_v_phase};
    assign w_frame_wrap   = w_h_wrap & w_v_wrap;

    logic [POS_W-1:0]   r_hpos;
    logic [POS_W-1:0]   r_vpos;
    logic               r_display_on;
    logic               r_hsync;
    logic               r_vsync;
    logic               r_line_start;
    logic               r_frame_start;
    logic [FRAME_W-1:0] r_frame_count;
    logic               r_first_frame;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hpos        <= '0;
            r_vpos        <= '0;
            r_display_on  <= 1'b0;
            r_hsync       <= ~H_SYNC_POL;
            r_vsync       <= ~V_SYNC_POL;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_count <= '0;
            r_first_frame <= 1'b1;
        end else if (ena) begin
            r_hpos        <= w_hpos_d;
            r_vpos        <= w_vpos_d;
            r_display_on  <= w_h_active & w_v_active;
            r_hsync       <= w_hsync_d;
            r_vsync       <= w_vsync_d;
            r_line_start  <= w_h_wrap;
            r_frame_start <= w_frame_wrap;
            // The wrap out of reset starts frame 0; only later wraps complete a frame.
            if (w_frame_wrap) begin
                if (r_first_frame) begin
                    r_first_frame <= 1'b0;
                end else begin
                    r_frame_count <= r_frame_count + FRAME_W'(1);
                end
            end
        end else begin
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end
    end

    assign hpos        = r_hpos;
    assign vpos        = r_vpos;
    assign display_on  = r_display_on;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;
    assign frame_count = r_frame_count;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Self-checking bench: default 640x480 instance driven from a vector table and hand sequences,
// plus a tiny-geometry instance checked every cycle against an arithmetic raster model.
module tb_vga_timing_ctrl;

    localparam int unsigned SHA = 8;
    localparam int unsigned SHF = 1;
    localparam int unsigned SHS = 2;
    localparam int unsigned SHB = 1;
    localparam int unsigned SVA = 4;
    localparam int unsigned SVF = 1;
    localparam int unsigned SVS = 1;
    localparam int unsigned SVB = 1;
    localparam int SHT = SHA + SHF + SHS + SHB;
    localparam int SVT = SVA + SVF + SVS + SVB;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n_a = 1'b0;
    logic       ena_a   = 1'b1;
    logic [9:0] a_hpos, a_vpos;
    logic       a_display_on, a_hsync, a_vsync, a_line_start, a_frame_start;
    logic [7:0] a_frame_count;

    logic       rst_n_b = 1'b0;
    logic       ena_b   = 1'b1;
    logic [9:0] b_hpos, b_vpos;
    logic       b_display_on, b_hsync, b_vsync, b_line_start, b_frame_start;
    logic [7:0] b_frame_count;

    vga_timing_ctrl dut_a (
        .clk         (clk),
        .rst_n       (rst_n_a),
        .ena         (ena_a),
        .hpos        (a_hpos),
        .vpos        (a_vpos),
        .display_on  (a_display_on),
        .hsync       (a_hsync),
        .vsync       (a_vsync),
        .line_start  (a_line_start),
        .frame_start (a_frame_start),
        .frame_count (a_frame_count)
    );

    vga_timing_ctrl #(
        .H_ACTIVE (SHA), .H_FRONT (SHF), .H_SYNC (SHS), .H_BACK (SHB),
        .V_ACTIVE (SVA), .V_FRONT (SVF), .V_SYNC (SVS), .V_BACK (SVB),
        .FRAME_W  (8)
    ) dut_b (
        .clk         (clk),
        .rst_n       (rst_n_b),
        .ena         (ena_b),
        .hpos        (b_hpos),
        .vpos        (b_vpos),
        .display_on  (b_display_on),
        .hsync       (b_hsync),
        .vsync       (b_vsync),
        .line_start  (b_line_start),
        .frame_start (b_frame_start),
        .frame_count (b_frame_count)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_a(input string name, input int hp, input int vp, input bit disp,
                           input bit hs, input bit vs, input bit ls, input bit fs, input int fc);
        chk({name, ".hpos"}, int'(a_hpos), hp);
        chk({name, ".vpos"}, int'(a_vpos), vp);
        chk({name, ".display_on"}, int'(a_display_on), int'(disp));
        chk({name, ".hsync"}, int'(a_hsync), int'(hs));
        chk({name, ".vsync"}, int'(a_vsync), int'(vs));
        chk({name, ".line_start"}, int'(a_line_start), int'(ls));
        chk({name, ".frame_start"}, int'(a_frame_start), int'(fs));
        chk({name, ".frame_count"}, int'(a_frame_count), fc);
    endtask

    // Raster model for dut_b: position, strobes and frame count from plain arithmetic.
    int m_h, m_v, m_fc;
    bit m_first, m_ls, m_fs, m_out_rst;
    bit b_chk_en = 1'b0;

    task automatic model_reset();
        m_h = SHT - 1;
        m_v = SVT - 1;
        m_fc = 0;
        m_first = 1'b1;
        m_ls = 1'b0;
        m_fs = 1'b0;
        m_out_rst = 1'b1;
    endtask

    always @(posedge clk or negedge rst_n_b) begin
        if (!rst_n_b) begin
            model_reset();
        end else if (ena_b) begin
            m_h = (m_h + 1) % SHT;
            if (m_h == 0) m_v = (m_v + 1) % SVT;
            m_ls = (m_h == 0);
            m_fs = m_ls && (m_v == 0);
            if (m_fs) begin
                if (m_first) m_first = 1'b0;
                else m_fc = (m_fc + 1) % 256;
            end
            m_out_rst = 1'b0;
        end else begin
            m_ls = 1'b0;
            m_fs = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (b_chk_en) begin
            bit in_hs, in_vs;
            in_hs = !m_out_rst && m_h >= SHA + SHF && m_h < SHA + SHF + SHS;
            in_vs = !m_out_rst && m_v >= SVA + SVF && m_v < SVA + SVF + SVS;
            chk("b.hpos", int'(b_hpos), m_out_rst ? 0 : m_h);
            chk("b.vpos", int'(b_vpos), m_out_rst ? 0 : m_v);
            chk("b.display_on", int'(b_display_on),
                int'(!m_out_rst && m_h < SHA && m_v < SVA));
            chk("b.hsync", int'(b_hsync), in_hs ? 0 : 1);
            chk("b.vsync", int'(b_vsync), in_vs ? 0 : 1);
            chk("b.line_start", int'(b_line_start), int'(m_ls));
            chk("b.frame_start", int'(b_frame_start), int'(m_fs));
            chk("b.frame_count", int'(b_frame_count), m_fc);
        end
    end

    typedef struct {
        bit ena;
        int cycles;
        int hp;
        int vp;
        bit disp;
        bit hs;
        bit vs;
        bit ls;
        bit fs;
    } vec_t;

    vec_t vecs[18];

    initial begin
        int per, hs_lo, dis_lo, hs_first, hs_last, pv;
        int fs_t[4], fs_fc[4], n_fs, vs_lo, prev_fc;
        bit found, wrapped;

        vecs[0]  = '{1'b1, 1,   0,   0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[1]  = '{1'b1, 1,   1,   0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 638, 639, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1,   640, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 15,  655, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 1,   656, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 95,  751, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 1,   752, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 47,  799, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 1,   0,   1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 2,   0,   1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 100, 100, 1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 5,   100, 1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[13] = '{1'b1, 1,   101, 1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[14] = '{1'b1, 698, 799, 1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[15] = '{1'b0, 5,   799, 1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[16] = '{1'b1, 1,   0,   2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[17] = '{1'b1, 300, 300, 2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

        model_reset();
        repeat (3) tick();
        b_chk_en = 1'b1;
        check_a("reset", 0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0);
        rst_n_a = 1'b1;

        for (int i = 0; i < 18; i++) begin
            ena_a = vecs[i].ena;
            if (!vecs[i].ena) begin
                for (int c = 0; c < vecs[i].cycles; c++) begin
                    tick();
                    check_a($sformatf("vec%0d.stall", i), vecs[i].hp, vecs[i].vp, vecs[i].disp,
                            vecs[i].hs, vecs[i].vs, vecs[i].ls, vecs[i].fs, 0);
                end
            end else begin
                repeat (vecs[i].cycles) tick();
                check_a($sformatf("vec%0d", i), vecs[i].hp, vecs[i].vp, vecs[i].disp,
                        vecs[i].hs, vecs[i].vs, vecs[i].ls, vecs[i].fs, 0);
            end
        end
        ena_a = 1'b1;

        // One full line: strobe period, hsync window and blanking width.
        found = 1'b0;
        for (int i = 0; i < 1000 && !found; i++) begin
            tick();
            if (a_line_start) found = 1'b1;
        end
        chk("line_start_seen", int'(found), 1);
        per = 0; hs_lo = 0; dis_lo = 0; hs_first = -1; hs_last = -1; pv = -1;
        found = 1'b0;
        for (int i = 0; i < 1000 && !found; i++) begin
            tick();
            per++;
            if (a_line_start) begin
                found = 1'b1;
            end else begin
                pv = int'(a_vpos);
                if (!a_hsync) begin
                    hs_lo++;
                    if (hs_first < 0) hs_first = int'(a_hpos);
                    hs_last = int'(a_hpos);
                end
                if (!a_display_on) dis_lo++;
            end
        end
        chk("line_period", per, 800);
        chk("hsync_low_cycles", hs_lo, 96);
        chk("hsync_first_hpos", hs_first, 656);
        chk("hsync_last_hpos", hs_last, 751);
        chk("blank_cycles", dis_lo, 160);
        chk("vpos_before_wrap", pv, 3);
        chk("vpos_after_wrap", int'(a_vpos), 4);

        // Asynchronous reset between edges, then restart from (0,0).
        repeat (300) tick();
        chk("pre_rst_hpos", int'(a_hpos), 300);
        #2;
        rst_n_a = 1'b0;
        #1;
        check_a("async_rst", 0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0);
        repeat (2) tick();
        ena_a = 1'b0;
        rst_n_a = 1'b1;
        tick();
        check_a("release_ena0", 0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0);
        ena_a = 1'b1;
        tick();
        check_a("restart", 0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 0);

        // Small geometry: three frames with ena held high.
        rst_n_b = 1'b1;
        n_fs = 0; vs_lo = 0;
        for (int i = 1; i <= 3 * SHT * SVT + 5; i++) begin
            tick();
            if (b_frame_start && n_fs < 4) begin
                fs_t[n_fs] = i;
                fs_fc[n_fs] = int'(b_frame_count);
                n_fs++;
            end
            if (n_fs == 1 && !b_vsync) vs_lo++;
        end
        chk("b.frame_starts", n_fs, 4);
        chk("b.first_fs_cycle", fs_t[0], 1);
        chk("b.frame_period1", fs_t[1] - fs_t[0], SHT * SVT);
        chk("b.frame_period2", fs_t[2] - fs_t[1], SHT * SVT);
        chk("b.fc_first", fs_fc[0], 0);
        chk("b.fc_second", fs_fc[1], 1);
        chk("b.fc_third", fs_fc[2], 2);
        chk("b.vsync_low_cycles", vs_lo, SVS * SHT);

        // Random enable with occasional mid-frame resets.
        for (int i = 0; i < 3000; i++) begin
            ena_b = ($urandom_range(3) != 0);
            if ($urandom_range(299) == 0) begin
                #2;
                rst_n_b = 1'b0;
                tick();
                rst_n_b = 1'b1;
            end else begin
                tick();
            end
        end

        // Long random-enable run, long enough for the frame counter to wrap.
        wrapped = 1'b0;
        for (int i = 0; i < 26000; i++) begin
            ena_b = ($urandom_range(31) != 0);
            prev_fc = m_fc;
            tick();
            if (prev_fc == 255 && m_fc == 0 && !wrapped) begin
                wrapped = 1'b1;
                chk("b.fc_wrap", int'(b_frame_count), 0);
                chk("b.fc_wrap_strobe", int'(b_frame_start), 1);
            end
        end
        chk("b.wrap_seen", int'(wrapped), 1);

        b_chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
